// File: rtl/sha256_msg_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sha256_ctrl_pkg
// Shared types and constants for the SHA-256 message controller:
//   state_e    - controller FSM states
//   pad_mode_e - which kind of padded block sha256_pad_gen should build
//   block geometry constants (bytes per block, length field size/position)
// -----------------------------------------------------------------------------
package sha256_ctrl_pkg;

  localparam int         BLOCK_BYTES = 64;
  localparam int         LEN_BYTES   = 8;
  localparam logic [7:0] PAD_BYTE    = 8'h80;
  localparam int         LEN_SLOT    = 56;

  // Highest last-byte index that still leaves room for the 0x80 marker
  // ahead of the length field in the same block.
  localparam int         LAST_SINGLE = LEN_SLOT - 2;

  typedef enum logic [2:0] {
    FILL,
    PAD,
    ISSUE,
    HOLD,
    BUSY,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    PAD_SINGLE,        // data, 0x80, zeros, length
    PAD_FIRST_OF_TWO,  // data, 0x80 (if room), zeros; length follows in next block
    PAD_LEN_ONLY       // optional 0x80 at byte 0, zeros, length
  } pad_mode_e;

endpackage

// File: rtl/sha256_msg_ctrl_if.sv
// -----------------------------------------------------------------------------
// sha256_msg_ctrl_if
// Bundles the three handshakes around the message controller:
//   byte stream  : s_tdata_i, s_tvalid_i, s_tlast_i -> s_tready_o
//   hasher       : hash_mode_o, hash_block_o, hash_first_o, hash_valid_o,
//                  hash_ready_i, digest_i
//   digest output: digest_o, dig_valid_o -> dig_ready_i
// Signal suffixes are from the controller's point of view.
// modport slave  - the controller itself
// modport master - its environment (byte source, hasher, digest consumer)
// -----------------------------------------------------------------------------
interface sha256_msg_ctrl_if;

  logic [7:0]   s_tdata_i;
  logic         s_tvalid_i;
  logic         s_tlast_i;
  logic         s_tready_o;

  logic         hash_mode_o;
  logic [511:0] hash_block_o;
  logic         hash_first_o;
  logic         hash_valid_o;
  logic         hash_ready_i;
  logic [255:0] digest_i;

  logic [255:0] digest_o;
  logic         dig_valid_o;
  logic         dig_ready_i;

  modport slave (
    input  s_tdata_i, s_tvalid_i, s_tlast_i, hash_ready_i, digest_i, dig_ready_i,
    output s_tready_o, hash_mode_o, hash_block_o, hash_first_o, hash_valid_o,
           digest_o, dig_valid_o
  );

  modport master (
    output s_tdata_i, s_tvalid_i, s_tlast_i, hash_ready_i, digest_i, dig_ready_i,
    input  s_tready_o, hash_mode_o, hash_block_o, hash_first_o, hash_valid_o,
           digest_o, dig_valid_o
  );

endinterface

// File: rtl/sha256_pad_gen.sv
// -----------------------------------------------------------------------------
// sha256_pad_gen
// Combinational builder for the padded SHA-256 blocks.
//   buf_i      - partially filled block, byte 0 at [511:504]
//   last_idx_i - index of the final message byte within buf_i
//   bit_len_i  - message length in bits (64-bit big-endian field)
//   mode_i     - single block / first of two / length-only
//   block_o    - padded block
// -----------------------------------------------------------------------------
module sha256_pad_gen
  import sha256_ctrl_pkg::*;
(
  input  logic [BLOCK_BYTES*8-1:0] buf_i,
  input  logic [5:0]               last_idx_i,
  input  logic [LEN_BYTES*8-1:0]   bit_len_i,
  input  pad_mode_e                mode_i,
  output logic [BLOCK_BYTES*8-1:0] block_o
);

  always_comb begin
    // NOTE: block_o gets a full default first so no path through this
    // process leaves it unassigned, which would infer a latch.
    block_o = '0;

    if (mode_i != PAD_LEN_ONLY) begin
      for (int j = 0; j < BLOCK_BYTES; j++) begin
        if (j <= int'(last_idx_i)) begin
          block_o[(BLOCK_BYTES-1-j)*8 +: 8] = buf_i[(BLOCK_BYTES-1-j)*8 +: 8];
        end else if (j == int'(last_idx_i) + 1) begin
          block_o[(BLOCK_BYTES-1-j)*8 +: 8] = PAD_BYTE;
        end
      end
    end

    // A message ending exactly on a block boundary had no room for the
    // marker, so it opens the length-only block instead.
    if (mode_i == PAD_LEN_ONLY && last_idx_i == 6'(BLOCK_BYTES - 1)) begin
      block_o[BLOCK_BYTES*8-1 -: 8] = PAD_BYTE;
    end

    if (mode_i != PAD_FIRST_OF_TWO) begin
      block_o[LEN_BYTES*8-1:0] = bit_len_i;
    end
  end

endmodule

// File: rtl/sha256_msg_ctrl.sv
// -----------------------------------------------------------------------------
// sha256_msg_ctrl
// Sequences a SHA-256 stream hasher for byte-serial messages: packs bytes
// big-endian into 512-bit blocks, applies padding and the 64-bit bit length,
// issues first/next blocks and returns each digest over valid/ready.
// Ports:
//   clk, reset_n - clock, asynchronous active-low reset
//   bus (slave)  - byte stream in, hasher block/handshake, digest out
// Parameters:
//   LEN_W - byte counter width (wraps modulo 2**LEN_W)
//   MODE  - constant driven on hash_mode_o (1 = SHA-256, 0 = SHA-224)
// -----------------------------------------------------------------------------
module sha256_msg_ctrl
  import sha256_ctrl_pkg::*;
#(
  parameter int LEN_W = 32,
  parameter bit MODE  = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  sha256_msg_ctrl_if.slave bus
);

  state_e                   state_q, state_d;
  logic [BLOCK_BYTES*8-1:0] buf_q, buf_d;
  logic [5:0]               idx_q, idx_d;
  logic [5:0]               last_idx_q, last_idx_d;
  logic [LEN_W-1:0]         count_q, count_d;
  logic                     more_q, more_d;     // another block follows
  logic                     pend_q, pend_d;     // next block is length-only
  logic                     first_q, first_d;
  logic [255:0]             digest_q, digest_d;
  logic                     dig_valid_q, dig_valid_d;

  logic                     byte_acc;
  logic                     idx_at_end;
  logic                     needs_two;
  pad_mode_e                pad_mode;
  logic [BLOCK_BYTES*8-1:0] pad_block;
  logic [LEN_BYTES*8-1:0]   bit_len;

  assign byte_acc   = (state_q == FILL) && bus.s_tvalid_i;
  assign idx_at_end = (idx_q == 6'(BLOCK_BYTES - 1));
  assign needs_two  = (last_idx_q > 6'(LAST_SINGLE));
  assign bit_len    = (LEN_BYTES*8)'(count_q) << 3;

  // The same generator serves PAD (data block) and the BUSY->ISSUE step
  // that builds the trailing length-only block.
  assign pad_mode = (state_q == BUSY) ? PAD_LEN_ONLY
                  : (needs_two ? PAD_FIRST_OF_TWO : PAD_SINGLE);

  sha256_pad_gen u_pad_gen (
    .buf_i      (buf_q),
    .last_idx_i (last_idx_q),
    .bit_len_i  (bit_len),
    .mode_i     (pad_mode),
    .block_o    (pad_block)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the clock edge.
    if (!reset_n) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FILL: begin
        if (byte_acc) begin
          if (bus.s_tlast_i)   state_d = PAD;
          else if (idx_at_end) state_d = ISSUE;
        end
      end
      PAD:   state_d = ISSUE;
      ISSUE: if (bus.hash_ready_i) state_d = HOLD;
      // The hasher's ready flag lags the valid strobe by a cycle.
      HOLD:  state_d = BUSY;
      BUSY: begin
        if (bus.hash_ready_i) begin
          if (more_q) state_d = pend_q ? ISSUE : FILL;
          else        state_d = DONE;
        end
      end
      DONE:    if (bus.dig_ready_i) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.s_tready_o   = (state_q == FILL);
    bus.hash_valid_o = (state_q == ISSUE) && bus.hash_ready_i;
  end

  assign bus.hash_mode_o  = MODE;
  assign bus.hash_block_o = buf_q;
  assign bus.hash_first_o = first_q;
  assign bus.digest_o     = digest_q;
  assign bus.dig_valid_o  = dig_valid_q;

  // ---------------------------------------------------------------------------
  // Datapath next-state: block buffer, counters, flags, digest
  // ---------------------------------------------------------------------------
  always_comb begin
    buf_d       = buf_q;
    idx_d       = idx_q;
    last_idx_d  = last_idx_q;
    count_d     = count_q;
    more_d      = more_q;
    pend_d      = pend_q;
    first_d     = first_q;
    digest_d    = digest_q;
    dig_valid_d = dig_valid_q;

    unique case (state_q)
      FILL: begin
        if (byte_acc) begin
          buf_d[(BLOCK_BYTES-1-int'(idx_q))*8 +: 8] = bus.s_tdata_i;
          count_d = count_q + LEN_W'(1);
          if (bus.s_tlast_i) begin
            last_idx_d = idx_q;
          end else if (idx_at_end) begin
            // Index stays at 63; it is cleared after the block is hashed.
            more_d = 1'b1;
            pend_d = 1'b0;
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
      end
      PAD: begin
        buf_d  = pad_block;
        more_d = needs_two;
        pend_d = needs_two;
      end
      ISSUE: begin
        if (bus.hash_ready_i) first_d = 1'b0;
      end
      BUSY: begin
        if (bus.hash_ready_i) begin
          if (more_q) begin
            idx_d = '0;
            if (pend_q) begin
              buf_d  = pad_block;
              more_d = 1'b0;
              pend_d = 1'b0;
            end else begin
              buf_d = '0;
            end
          end else begin
            digest_d    = bus.digest_i;
            dig_valid_d = 1'b1;
          end
        end
      end
      DONE: begin
        if (bus.dig_ready_i) begin
          dig_valid_d = 1'b0;
          count_d     = '0;
          idx_d       = '0;
          buf_d       = '0;
          first_d     = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the block buffer is a flop bank rather than a RAM, so it is
      // reset with the rest of the state and no stale bytes survive reset.
      buf_q       <= '0;
      idx_q       <= '0;
      last_idx_q  <= '0;
      count_q     <= '0;
      more_q      <= 1'b0;
      pend_q      <= 1'b0;
      first_q     <= 1'b1;
      digest_q    <= '0;
      dig_valid_q <= 1'b0;
    end else begin
      buf_q       <= buf_d;
      idx_q       <= idx_d;
      last_idx_q  <= last_idx_d;
      count_q     <= count_d;
      more_q      <= more_d;
      pend_q      <= pend_d;
      first_q     <= first_d;
      digest_q    <= digest_d;
      dig_valid_q <= dig_valid_d;
    end
  end

endmodule

// File: tb/tb_sha256_msg_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sha256_msg_ctrl
// Self-checking bench for sha256_msg_ctrl. A behavioural SHA-256 hasher sits
// on the hasher side of the interface; expected blocks come from padding the
// whole message as a byte queue, expected digests from hashing those blocks.
// -----------------------------------------------------------------------------
module tb_sha256_msg_ctrl;

  typedef logic [7:0]   byte_q_t [$];
  typedef logic [511:0] blk_q_t  [$];

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [255:0] IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] GOLD_ABC =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] GOLD_448 =
    256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  sha256_msg_ctrl_if bus ();

  sha256_msg_ctrl #(.LEN_W(32), .MODE(1'b1)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks   = 0;
  int failures = 0;

  // ---------------------------------------------------------------------------
  // Reference SHA-256
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] compress(input logic [255:0] h, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, hh, t1, t2, s0, s1;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    a = h[255:224]; b = h[223:192]; c = h[191:160]; d = h[159:128];
    e = h[127:96];  f = h[95:64];   g = h[63:32];   hh = h[31:0];
    for (int t = 0; t < 64; t++) begin
      s1 = ror(e, 6) ^ ror(e, 11) ^ ror(e, 25);
      t1 = hh + s1 + ((e & f) ^ (~e & g)) + K[t] + w[t];
      s0 = ror(a, 2) ^ ror(a, 13) ^ ror(a, 22);
      t2 = s0 + ((a & b) ^ (a & c) ^ (b & c));
      hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {h[255:224] + a, h[223:192] + b, h[191:160] + c, h[159:128] + d,
            h[127:96] + e,  h[95:64] + f,   h[63:32] + g,   h[31:0] + hh};
  endfunction

  // Whole-message padding: append 0x80, zero to 56 mod 64, 64-bit bit length.
  function automatic blk_q_t pad_msg(input byte_q_t msg);
    byte_q_t      p;
    blk_q_t       q;
    logic [63:0]  bl;
    logic [511:0] blk;
    p = msg;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    bl = 64'(msg.size()) * 64'd8;
    for (int i = 0; i < 8; i++) p.push_back(bl[63-8*i -: 8]);
    for (int bi = 0; bi < p.size() / 64; bi++) begin
      for (int j = 0; j < 64; j++) blk[511-8*j -: 8] = p[64*bi+j];
      q.push_back(blk);
    end
    return q;
  endfunction

  function automatic logic [255:0] sha_of(input blk_q_t blks);
    logic [255:0] h;
    h = IV;
    foreach (blks[i]) h = compress(h, blks[i]);
    return h;
  endfunction

  function automatic byte_q_t str2q(input string s);
    byte_q_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  function automatic byte_q_t fill_q(input int n, input logic [7:0] v);
    byte_q_t q;
    for (int i = 0; i < n; i++) q.push_back(v);
    return q;
  endfunction

  function automatic byte_q_t rand_q(input int n);
    byte_q_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  // ---------------------------------------------------------------------------
  // Behavioural hasher: takes a block on valid&ready, stays busy a random
  // number of cycles, then raises ready with the chained digest.
  // ---------------------------------------------------------------------------
  blk_q_t       act_blk;
  logic         act_first [$];
  logic [511:0] last_blk;
  logic [255:0] h_model;
  logic [255:0] h_next;
  int           busy_cnt;
  int           stab_err = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.hash_ready_i <= 1'b1;
      bus.digest_i     <= '0;
      h_model          <= '0;
      busy_cnt         <= 0;
    end else if (busy_cnt > 0) begin
      if (bus.hash_block_o !== last_blk) stab_err <= stab_err + 1;
      if (busy_cnt == 1) bus.hash_ready_i <= 1'b1;
      busy_cnt <= busy_cnt - 1;
    end else if (bus.hash_valid_o && bus.hash_ready_i) begin
      h_next = compress(bus.hash_first_o ? IV : h_model, bus.hash_block_o);
      h_model          <= h_next;
      bus.digest_i     <= h_next;
      bus.hash_ready_i <= 1'b0;
      busy_cnt         <= int'($urandom_range(10, 3));
      last_blk         <= bus.hash_block_o;
      act_blk.push_back(bus.hash_block_o);
      act_first.push_back(bus.hash_first_o);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic send_msg(input byte_q_t msg, input int gap_pct);
    int i   = 0;
    int cyc = 0;
    while (i < msg.size() && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (int'($urandom_range(99)) < gap_pct) begin
        bus.s_tvalid_i = 1'b0;
        bus.s_tlast_i  = 1'b0;
        bus.s_tdata_i  = 8'($urandom);
      end else begin
        bus.s_tvalid_i = 1'b1;
        bus.s_tdata_i  = msg[i];
        bus.s_tlast_i  = (i == msg.size() - 1);
        if (bus.s_tready_o) i++;
      end
    end
    @(negedge clk);
    bus.s_tvalid_i = 1'b0;
    bus.s_tlast_i  = 1'b0;
    checks++;
    if (i != msg.size()) begin
      failures++;
      $display("FAIL send_msg: accepted %0d bytes, required %0d", i, msg.size());
    end
  endtask

  task automatic run_msg(input string name, input byte_q_t msg, input int gap_pct,
                         input int hold, input logic use_gold, input logic [255:0] gold,
                         output logic [255:0] got);
    blk_q_t       exp_b;
    logic [255:0] exp_d;
    int           stab0;
    int           cyc;
    exp_b = pad_msg(msg);
    exp_d = sha_of(exp_b);
    act_blk.delete();
    act_first.delete();
    stab0 = stab_err;
    got   = '0;
    bus.dig_ready_i = 1'b0;
    send_msg(msg, gap_pct);

    cyc = 0;
    while (!bus.dig_valid_o && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (!bus.dig_valid_o) begin
      failures++;
      $display("FAIL %s dig_valid timeout: got 0, required 1", name);
      return;
    end
    got = bus.digest_o;

    checks++;
    if (act_blk.size() != exp_b.size()) begin
      failures++;
      $display("FAIL %s issue_count: got %0d, required %0d", name, act_blk.size(), exp_b.size());
    end
    for (int bi = 0; bi < act_blk.size() && bi < exp_b.size(); bi++) begin
      checks++;
      if (act_blk[bi] !== exp_b[bi]) begin
        failures++;
        $display("FAIL %s block%0d: got %h required %h", name, bi, act_blk[bi], exp_b[bi]);
      end
      checks++;
      if (act_first[bi] !== (bi == 0)) begin
        failures++;
        $display("FAIL %s first%0d: got %b, required %b", name, bi, act_first[bi], bi == 0);
      end
    end
    checks++;
    if (bus.digest_o !== exp_d) begin
      failures++;
      $display("FAIL %s digest: got %h, required %h", name, bus.digest_o, exp_d);
    end
    if (use_gold) begin
      checks++;
      if (bus.digest_o !== gold) begin
        failures++;
        $display("FAIL %s golden: got %h, required %h", name, bus.digest_o, gold);
      end
    end
    checks++;
    if (stab_err != stab0) begin
      failures++;
      $display("FAIL %s block_stable: got %0d changes, required 0", name, stab_err - stab0);
    end

    for (int c = 0; c < hold; c++) begin
      @(negedge clk);
      checks++;
      if (bus.digest_o !== got || bus.dig_valid_o !== 1'b1 || bus.s_tready_o !== 1'b0) begin
        failures++;
        $display("FAIL %s hold%0d: digest %h valid %b tready %b, required %h 1 0",
                 name, c, bus.digest_o, bus.dig_valid_o, bus.s_tready_o, got);
      end
    end

    bus.dig_ready_i = 1'b1;
    @(negedge clk);
    bus.dig_ready_i = 1'b0;
    checks++;
    if (bus.dig_valid_o !== 1'b0 || bus.s_tready_o !== 1'b1) begin
      failures++;
      $display("FAIL %s accept: valid %b tready %b, required 0 1",
               name, bus.dig_valid_o, bus.s_tready_o);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (bus.s_tready_o !== 1'b1 || bus.hash_valid_o !== 1'b0 || bus.hash_first_o !== 1'b1 ||
        bus.dig_valid_o !== 1'b0 || bus.digest_o !== '0 || bus.hash_block_o !== '0 ||
        bus.hash_mode_o !== 1'b1) begin
      failures++;
      $display("FAIL %s: tready %b hvalid %b first %b dvalid %b mode %b digest %h, required 1 0 1 0 1 0",
               name, bus.s_tready_o, bus.hash_valid_o, bus.hash_first_o, bus.dig_valid_o,
               bus.hash_mode_o, bus.digest_o);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    bus.s_tdata_i   = '0;
    bus.s_tvalid_i  = 1'b0;
    bus.s_tlast_i   = 1'b0;
    bus.dig_ready_i = 1'b0;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_asserted");
    reset_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset_released");
  endtask

  task automatic test_abc();
    logic [255:0] d;
    run_msg("abc", str2q("abc"), 0, 0, 1'b1, GOLD_ABC, d);
  endtask

  task automatic test_two_block();
    logic [255:0] d;
    run_msg("msg448", str2q("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq"),
            0, 0, 1'b1, GOLD_448, d);
    checks++;
    if (act_blk.size() != 2 || act_blk[1] !== 512'h1c0) begin
      failures++;
      $display("FAIL msg448 len_block: issues %0d, required 2 with zeros + 0x1c0", act_blk.size());
    end
  endtask

  task automatic test_boundaries();
    int           lens [7] = '{55, 56, 63, 64, 119, 120, 128};
    logic [255:0] d;
    logic [511:0] exp64;
    foreach (lens[i]) begin
      run_msg($sformatf("a_x%0d", lens[i]), fill_q(lens[i], 8'h61), 0, 0, 1'b0, '0, d);
      if (lens[i] == 64) begin
        exp64 = {8'h80, 440'h0, 64'h200};
        checks++;
        if (act_blk.size() != 2 || act_blk[1] !== exp64) begin
          failures++;
          $display("FAIL a_x64 len_block: issues %0d, required 2 with 0x80 at byte 0 + 0x200",
                   act_blk.size());
        end
      end
    end
  endtask

  task automatic test_random();
    logic [255:0] d;
    for (int m = 0; m < 8; m++) begin
      run_msg($sformatf("rand%0d", m), rand_q(int'($urandom_range(200, 1))), 40, 0, 1'b0, '0, d);
    end
  endtask

  task automatic test_backpressure();
    logic [255:0] d;
    run_msg("backpressure", rand_q(30), 50, 20, 1'b0, '0, d);
  endtask

  task automatic test_back_to_back();
    logic [255:0] d1, d2;
    run_msg("b2b_first", str2q("abc"), 0, 0, 1'b1, GOLD_ABC, d1);
    run_msg("b2b_second", str2q("abc"), 0, 0, 1'b1, GOLD_ABC, d2);
    checks++;
    if (d1 !== d2) begin
      failures++;
      $display("FAIL b2b_same: got %h, required %h", d2, d1);
    end
  endtask

  task automatic test_reset_busy();
    logic [255:0] d;
    int           cyc = 0;
    act_blk.delete();
    act_first.delete();
    send_msg(fill_q(60, 8'h5a), 0);
    while (act_blk.size() < 1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    checks++;
    if (act_blk.size() != 1 || bus.s_tready_o !== 1'b0 || bus.hash_ready_i !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy reach: issues %0d tready %b hready %b, required 1 0 0",
               act_blk.size(), bus.s_tready_o, bus.hash_ready_i);
    end
    reset_n = 1'b0;
    #1;
    check_reset_outputs("reset_busy");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset_busy_released");
    run_msg("abc_after_reset", str2q("abc"), 0, 0, 1'b1, GOLD_ABC, d);
  endtask

  initial begin
    test_reset();
    test_abc();
    test_two_block();
    test_boundaries();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
